// File: rtl/sha256_pkg.sv
// Shared types, constants and SHA-256 bit functions for the compression engine.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Standard initial hash value, H0 in the top word.
  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t bsig0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round; chained UNROLL times by the core.
module sha256_round
  import sha256_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  input  word_t e,
  input  word_t f,
  input  word_t g,
  input  word_t h,
  input  word_t w,
  input  word_t k,
  output word_t a_next,
  output word_t b_next,
  output word_t c_next,
  output word_t d_next,
  output word_t e_next,
  output word_t f_next,
  output word_t g_next,
  output word_t h_next
);

  word_t t1;
  word_t t2;

  assign t1 = h + bsig1(e) + ch(e, f, g) + k + w;
  assign t2 = bsig0(a) + maj(a, b, c);

  assign a_next = t1 + t2;
  assign b_next = a;
  assign c_next = b;
  assign d_next = c;
  assign e_next = d + t1;
  assign f_next = e;
  assign g_next = f;
  assign h_next = g;

endmodule

// File: rtl/sha256_chain_core.sv
// SHA-256 compression engine with arbitrary chaining input, a rolling 16-word
// message schedule and UNROLL rounds per clock.
module sha256_chain_core
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block_in,
  input  logic [255:0] hash_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] hash_out,
  output logic         busy
);

  genvar gi;

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $fatal(1, "sha256_chain_core: UNROLL must be 1, 2, 4 or 8");
  end

  state_t            state_reg, state_next;
  logic              out_valid_reg;
  logic [6:0]        cnt_reg;
  logic [0:7][31:0]  chain_reg;
  logic [0:7][31:0]  work_reg;
  logic [0:7][31:0]  round_out;
  logic [0:7][31:0]  sum;
  logic [255:0]      hash_reg;
  word_t             win_reg [0:15];
  word_t             ext [0:15+UNROLL];

  // Extend the window with the UNROLL words consumed this cycle; later words
  // reuse earlier newly computed ones so all needed W are ready in one cycle.
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = win_reg[i];
    for (int j = 0; j < UNROLL; j++)
      ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
  end

  for (gi = 0; gi < UNROLL; gi++) begin : g_round
    logic [0:7][31:0] st_in;
    logic [0:7][31:0] st_out;
    logic [5:0]       kidx;

    if (gi == 0) begin : g_first
      assign st_in = work_reg;
    end else begin : g_chain
      assign st_in = g_round[gi-1].st_out;
    end

    assign kidx = cnt_reg[5:0] + 6'(gi);

    sha256_round u_round (
      .a(st_in[0]), .b(st_in[1]), .c(st_in[2]), .d(st_in[3]),
      .e(st_in[4]), .f(st_in[5]), .g(st_in[6]), .h(st_in[7]),
      .w(ext[gi]), .k(K[kidx]),
      .a_next(st_out[0]), .b_next(st_out[1]), .c_next(st_out[2]), .d_next(st_out[3]),
      .e_next(st_out[4]), .f_next(st_out[5]), .g_next(st_out[6]), .h_next(st_out[7])
    );
  end

  assign round_out = g_round[UNROLL-1].st_out;

  for (gi = 0; gi < 8; gi++) begin : g_sum
    assign sum[gi] = chain_reg[gi] + work_reg[gi];
  end

  // Next-state logic and decoded handshake outputs; clear overrides everything.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = ROUND;
      end
      ROUND:   if (cnt_reg == 7'(64 - UNROLL)) state_next = FINAL;
      FINAL:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // State register; out_valid is registered and high exactly while in DONE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= (state_next == DONE);
    end
  end

  // Datapath: load on accept, step the rounds and window, register the result.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_reg   <= '0;
      chain_reg <= '0;
      work_reg  <= '0;
      hash_reg  <= '0;
      for (int i = 0; i < 16; i++) win_reg[i] <= '0;
    end else if (!clear) begin
      case (state_reg)
        IDLE: if (in_valid) begin
          chain_reg <= hash_in;
          work_reg  <= hash_in;
          cnt_reg   <= '0;
          for (int i = 0; i < 16; i++) win_reg[i] <= block_in[511-32*i -: 32];
        end
        ROUND: begin
          work_reg <= round_out;
          cnt_reg  <= cnt_reg + 7'(UNROLL);
          for (int i = 0; i < 16; i++) win_reg[i] <= ext[i+UNROLL];
        end
        FINAL:   hash_reg <= sum;
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign hash_out  = hash_reg;

endmodule

// File: tb/tb_sha256_chain_core.sv
// Scoreboard bench: one core per legal UNROLL, each with its own driver and
// monitor, checked against a full 64-word reference compression model.
`timescale 1ns/1ps
module tb_sha256_chain_core;
  import sha256_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  localparam logic [255:0] H_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] H_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] H_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001c0};

  typedef struct {
    logic [255:0] h;
    int           acc;
  } exp_t;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: full 64-entry schedule, then 64 rounds, then feed-forward.
  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_u
    localparam int U   = 1 << gi;
    localparam int LAT = 64 / U + 1;

    logic         n_rst     = 1'b0;
    logic         clear     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic [511:0] block_in  = '0;
    logic [255:0] hash_in   = '0;
    logic         in_ready, out_valid, busy;
    logic [255:0] hash_out;

    exp_t sb [$];
    bit   done_f    = 1'b0;
    bit   rise_seen = 1'b0;
    int   rise_cyc  = 0;

    sha256_chain_core #(.UNROLL(U)) dut (
      .clk(clk), .n_rst(n_rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .block_in(block_in), .hash_in(hash_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .hash_out(hash_out), .busy(busy)
    );

    task automatic ck(input string name, input logic [255:0] act, input logic [255:0] req);
      chk($sformatf("U%0d %s", U, name), act, req);
    endtask

    // Present a block and hold it until the core accepts it.
    task automatic send(input logic [511:0] blk, input logic [255:0] hin,
                        input logic [255:0] exp_h, input bit push, output int acc);
      bit r;
      int tries;
      tries    = 0;
      block_in = blk;
      hash_in  = hin;
      in_valid = 1'b1;
      do begin
        r = in_ready;
        @(posedge clk); #1;
        tries++;
      end while (!r && tries < 400);
      ck("accept", r, 1'b1);
      acc      = cyc;
      in_valid = 1'b0;
      block_in = {16{$urandom}};
      hash_in  = {8{$urandom}};
      if (push) sb.push_back('{exp_h, acc});
    endtask

    task automatic drain();
      int t;
      t = 0;
      while ((sb.size() != 0 || busy || out_valid) && t < 400) begin
        @(posedge clk); #1;
        t++;
      end
      ck("drain in time", t < 400, 1'b1);
    endtask

    task automatic wait_valid();
      int t;
      t = 0;
      while (!out_valid && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      ck("out_valid in time", out_valid, 1'b1);
    endtask

    // Monitor: pop and compare on every output handshake.
    initial begin
      exp_t e;
      forever begin
        @(negedge clk);
        if (!n_rst) rise_seen = 1'b0;
        else if (out_valid) begin
          if (!rise_seen) begin
            rise_seen = 1'b1;
            rise_cyc  = cyc;
          end
          if (out_ready) begin
            if (sb.size() == 0) ck("unexpected output", out_valid, 1'b0);
            else begin
              e = sb.pop_front();
              ck("hash", hash_out, e.h);
              ck("latency", rise_cyc - e.acc, LAT);
            end
            rise_seen = 1'b0;
          end
        end
      end
    end

    // Driver.
    initial begin
      logic [255:0] h1;
      logic [511:0] rb;
      logic [255:0] rh;
      int a0, a1, ov;
      a0 = 0;
      repeat (3) @(posedge clk); #1;
      ck("reset in_ready", in_ready, 1'b1);
      ck("reset busy", busy, 1'b0);
      ck("reset out_valid", out_valid, 1'b0);
      ck("reset hash_out", hash_out, '0);
      n_rst = 1'b1;
      @(posedge clk); #1;

      send(B_ABC, IV, H_ABC, 1'b1, a0);
      drain();
      send(B_EMPTY, IV, H_EMPTY, 1'b1, a0);
      drain();

      send(B_TWO1, IV, ref_compress(IV, B_TWO1), 1'b1, a0);
      drain();
      h1 = hash_out;
      send(B_TWO2, h1, H_TWO, 1'b1, a0);
      drain();

      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 16; j++) rb[511-32*j -: 32] = $urandom;
        for (int j = 0; j < 8; j++) rh[255-32*j -: 32] = $urandom;
        send(rb, rh, ref_compress(rh, rb), 1'b1, a1);
        if (i > 0) ck("accept interval", a1 - a0, 64 / U + 3);
        a0 = a1;
      end
      drain();

      // Stall in DONE with a competing block waiting.
      out_ready = 1'b0;
      send(B_ABC, IV, H_ABC, 1'b1, a0);
      wait_valid();
      block_in = B_EMPTY;
      hash_in  = IV;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
        ck("stall out_valid", out_valid, 1'b1);
        ck("stall in_ready", in_ready, 1'b0);
        ck("stall hash_out", hash_out, H_ABC);
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      ck("idle after release", busy, 1'b0);
      ck("ready after release", in_ready, 1'b1);
      @(posedge clk); #1;
      ck("accept after release", busy, 1'b1);
      a0 = cyc;
      sb.push_back('{H_EMPTY, a0});
      in_valid = 1'b0;
      drain();

      // Abort around round 30.
      send(B_ABC, IV, H_ABC, 1'b0, a0);
      repeat (30 / U) @(posedge clk); #1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      ck("clear busy", busy, 1'b0);
      ck("clear in_ready", in_ready, 1'b1);
      ck("clear out_valid", out_valid, 1'b0);
      ck("clear hash_out", hash_out, H_EMPTY);
      ov = 0;
      for (int i = 0; i < 80; i++) begin
        @(posedge clk); #1;
        if (out_valid) ov++;
      end
      ck("no out_valid after clear", ov, 0);
      ck("hash_out kept after clear", hash_out, H_EMPTY);

      block_in = B_ABC;
      hash_in  = IV;
      in_valid = 1'b1;
      clear    = 1'b1;
      @(posedge clk); #1;
      ck("clear beats in_valid", busy, 1'b0);
      in_valid = 1'b0;
      clear    = 1'b0;
      send(B_ABC, IV, H_ABC, 1'b1, a0);
      drain();

      // Asynchronous reset in the middle of the rounds.
      send(B_EMPTY, IV, H_EMPTY, 1'b0, a0);
      repeat (32 / U) @(posedge clk); #1;
      n_rst = 1'b0;
      #1;
      ck("async rst busy", busy, 1'b0);
      ck("async rst in_ready", in_ready, 1'b1);
      ck("async rst out_valid", out_valid, 1'b0);
      ck("async rst hash_out", hash_out, '0);
      @(posedge clk); #1;
      n_rst = 1'b1;
      @(posedge clk); #1;
      for (int j = 0; j < 16; j++) rb[511-32*j -: 32] = $urandom;
      for (int j = 0; j < 8; j++) rh[255-32*j -: 32] = $urandom;
      send(rb, rh, ref_compress(rh, rb), 1'b1, a0);
      drain();
      done_f = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(g_u[0].done_f && g_u[1].done_f && g_u[2].done_f && g_u[3].done_f) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 20000) begin
      total++;
      $display("FAIL suite timeout: still running after %0d cycles, required all suites finished", t);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
